// File: rtl/prog_cntr_param_if.sv
// Fetch-PC bundle: redirect/stall controls in, fetch PC, branch base PC and
// trap PC out. The master drives the controls; the PC block is the slave.
interface prog_cntr_param_if #(
  parameter int XLEN = 32
);
  logic            stall_vald;
  logic            trap_vald;
  logic            jalr_vald;
  logic [XLEN-1:0] jalr_addr;
  logic            branch_vald;
  logic [XLEN-1:0] imm;
  logic            ilen16;
  logic [XLEN-1:0] prog_cntr;
  logic [XLEN-1:0] prog_cntr_base;
  logic            redirect_vald;
  logic [XLEN-1:0] epc;

  modport master (
    output stall_vald, trap_vald, jalr_vald, jalr_addr, branch_vald, imm, ilen16,
    input  prog_cntr, prog_cntr_base, redirect_vald, epc
  );

  modport slave (
    input  stall_vald, trap_vald, jalr_vald, jalr_addr, branch_vald, imm, ilen16,
    output prog_cntr, prog_cntr_base, redirect_vald, epc
  );
endinterface

// File: rtl/prog_cntr_param.sv
// Fetch program counter with HIST_DEPTH-deep PC history for late branch
// resolution, trap redirect with EPC capture and optional compressed stepping.
module prog_cntr_param #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = 'h100,
  parameter int              HIST_DEPTH = 1,
  parameter bit              C_EXT      = 1'b0
) (
  input  logic               clk,
  input  logic               srst_n,
  prog_cntr_param_if.slave   bus
);

  logic [XLEN-1:0] prog_cntr_q;
  logic [XLEN-1:0] pc_hist [HIST_DEPTH];
  logic [XLEN-1:0] epc_q;
  logic            redirect_q;

  logic [XLEN-1:0] base_pc;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] next_pc;
  logic            redirect_next;
  logic            hist_shift;

  assign base_pc    = pc_hist[HIST_DEPTH-1];
  assign step       = (C_EXT && bus.ilen16) ? XLEN'(2) : XLEN'(4);
  // A trap overrides a stall, so the history still advances on a trap cycle.
  assign hist_shift = bus.trap_vald | ~bus.stall_vald;

  // NOTE: next_pc is assigned on every path of the if/else chain so the
  // block stays purely combinational; a missing branch would infer a latch.
  always_comb begin
    next_pc = prog_cntr_q + step;
    if (bus.trap_vald)        next_pc = TRAP_VEC;
    else if (bus.stall_vald)  next_pc = prog_cntr_q;
    else if (bus.jalr_vald)   next_pc = bus.jalr_addr & ~XLEN'(1);
    else if (bus.branch_vald) next_pc = base_pc + bus.imm;
  end

  // A redirect held off by a stall is dropped; the hazard unit re-presents it.
  assign redirect_next = bus.trap_vald |
                         (~bus.stall_vald & (bus.jalr_vald | bus.branch_vald));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; pc_hist[i] <= pc_hist[i-1] relies on this.
  // NOTE: the history array is reset entry by entry because the branch base
  // must equal RESET_VEC until real fetch PCs have shifted in.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      prog_cntr_q <= RESET_VEC;
      redirect_q  <= 1'b0;
      epc_q       <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) pc_hist[i] <= RESET_VEC;
    end else begin
      prog_cntr_q <= next_pc;
      redirect_q  <= redirect_next;
      if (bus.trap_vald) epc_q <= base_pc;
      if (hist_shift) begin
        pc_hist[0] <= prog_cntr_q;
        for (int i = 1; i < HIST_DEPTH; i++) pc_hist[i] <= pc_hist[i-1];
      end
    end
  end

  assign bus.prog_cntr      = prog_cntr_q;
  assign bus.prog_cntr_base = base_pc;
  assign bus.redirect_vald  = redirect_q;
  assign bus.epc            = epc_q;

endmodule

// File: tb/tb_prog_cntr_param.sv
// Bench for prog_cntr_param: two instances (HIST_DEPTH=3/C_EXT=1 and
// HIST_DEPTH=1/C_EXT=0) share stimulus and are checked against a PC model.
module tb_prog_cntr_param;

  logic clk = 1'b0;
  logic srst_n;
  always #5 clk = ~clk;

  prog_cntr_param_if #(.XLEN(32)) if_a ();
  prog_cntr_param_if #(.XLEN(32)) if_b ();

  prog_cntr_param #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100),
                    .HIST_DEPTH(3), .C_EXT(1'b1))
    dut_a (.clk(clk), .srst_n(srst_n), .bus(if_a.slave));

  prog_cntr_param #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100),
                    .HIST_DEPTH(1), .C_EXT(1'b0))
    dut_b (.clk(clk), .srst_n(srst_n), .bus(if_b.slave));

  assign if_b.stall_vald  = if_a.stall_vald;
  assign if_b.trap_vald   = if_a.trap_vald;
  assign if_b.jalr_vald   = if_a.jalr_vald;
  assign if_b.jalr_addr   = if_a.jalr_addr;
  assign if_b.branch_vald = if_a.branch_vald;
  assign if_b.imm         = if_a.imm;
  assign if_b.ilen16      = if_a.ilen16;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: fetch PC plus a list of previously fetched PCs (newest first);
  // the branch base is simply the PC fetched HIST_DEPTH advances ago.
  logic [31:0] m_pc    [2];
  logic [31:0] m_past  [2][8];
  logic [31:0] m_epc   [2];
  logic        m_redir [2];

  function automatic int hd_of(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic bit cext_of(input int k);
    return (k == 0);
  endfunction

  always @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pc[k] = 32'h0; m_epc[k] = 32'h0; m_redir[k] = 1'b0;
        for (int i = 0; i < 8; i++) m_past[k][i] = 32'h0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [31:0] base, nxt;
        base = m_past[k][hd_of(k)-1];
        if (if_a.trap_vald) begin
          nxt = 32'h100;
          m_epc[k] = base;
        end else if (if_a.stall_vald) nxt = m_pc[k];
        else if (if_a.jalr_vald)      nxt = {if_a.jalr_addr[31:1], 1'b0};
        else if (if_a.branch_vald)    nxt = base + if_a.imm;
        else nxt = m_pc[k] + ((cext_of(k) && if_a.ilen16) ? 32'd2 : 32'd4);
        m_redir[k] = if_a.trap_vald |
                     (!if_a.stall_vald && (if_a.jalr_vald || if_a.branch_vald));
        if (if_a.trap_vald || !if_a.stall_vald) begin
          for (int i = 7; i > 0; i--) m_past[k][i] = m_past[k][i-1];
          m_past[k][0] = m_pc[k];
        end
        m_pc[k] = nxt;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("cmp_a_pc",    if_a.prog_cntr,      m_pc[0]);
      check("cmp_a_base",  if_a.prog_cntr_base, m_past[0][2]);
      check("cmp_a_redir", 32'(if_a.redirect_vald), 32'(m_redir[0]));
      check("cmp_a_epc",   if_a.epc,            m_epc[0]);
      check("cmp_b_pc",    if_b.prog_cntr,      m_pc[1]);
      check("cmp_b_base",  if_b.prog_cntr_base, m_past[1][0]);
      check("cmp_b_redir", 32'(if_b.redirect_vald), 32'(m_redir[1]));
      check("cmp_b_epc",   if_b.epc,            m_epc[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    srst_n = 1'b0;
    if_a.stall_vald = 1'b0; if_a.trap_vald = 1'b0; if_a.jalr_vald = 1'b0;
    if_a.jalr_addr = 32'h0; if_a.branch_vald = 1'b0; if_a.imm = 32'h0;
    if_a.ilen16 = 1'b0;
    repeat (3) step();
    checking = 1'b1;
    check("rst_a_pc",  if_a.prog_cntr, 32'h0);
    check("rst_a_epc", if_a.epc, 32'h0);
    srst_n = 1'b1;

    // 1: sequential run, base lags by HIST_DEPTH
    step(); check("seq_a_pc4", if_a.prog_cntr, 32'h4);
    step(); check("seq_a_pc8", if_a.prog_cntr, 32'h8);
    step(); check("seq_a_pcC", if_a.prog_cntr, 32'hC);
    check("seq_a_base", if_a.prog_cntr_base, 32'h0);
    check("seq_b_base", if_b.prog_cntr_base, 32'h8);
    check("seq_redir",  32'(if_a.redirect_vald), 32'h0);

    // 2: branch from base 0x8 (depth 3) / 0x10 (depth 1)
    step(); step();
    check("br_a_pre", if_a.prog_cntr, 32'h14);
    check("br_a_base", if_a.prog_cntr_base, 32'h8);
    if_a.branch_vald = 1'b1; if_a.imm = 32'h20;
    step();
    if_a.branch_vald = 1'b0;
    check("br_a_pc", if_a.prog_cntr, 32'h28);
    check("br_b_pc", if_b.prog_cntr, 32'h30);
    check("br_redir", 32'(if_a.redirect_vald), 32'h1);
    step();
    check("br_a_next", if_a.prog_cntr, 32'h2C);
    check("br_redir_clr", 32'(if_a.redirect_vald), 32'h0);

    // 3: stall beats jalr, then jalr taken with bit0 cleared
    if_a.jalr_vald = 1'b1; if_a.jalr_addr = 32'h40;
    step();
    check("jalr_pc40", if_a.prog_cntr, 32'h40);
    check("stall_a_base0", if_a.prog_cntr_base, 32'h14);
    if_a.stall_vald = 1'b1; if_a.jalr_addr = 32'h201;
    step();
    check("stall_pc1", if_a.prog_cntr, 32'h40);
    check("stall_redir1", 32'(if_a.redirect_vald), 32'h0);
    step();
    check("stall_pc2", if_a.prog_cntr, 32'h40);
    check("stall_a_base2", if_a.prog_cntr_base, 32'h14);
    check("stall_b_base2", if_b.prog_cntr_base, 32'h34);
    if_a.stall_vald = 1'b0;
    step();
    if_a.jalr_vald = 1'b0;
    check("jalr_pc200", if_a.prog_cntr, 32'h200);
    check("jalr_redir", 32'(if_a.redirect_vald), 32'h1);
    check("jalr_a_base", if_a.prog_cntr_base, 32'h28);

    // 4: trap wins over stall and branch, epc takes the base PC
    if_a.jalr_vald = 1'b1; if_a.jalr_addr = 32'h1C;
    step();
    if_a.jalr_vald = 1'b0;
    step();
    check("trap_b_base", if_b.prog_cntr_base, 32'h1C);
    if_a.trap_vald = 1'b1; if_a.stall_vald = 1'b1; if_a.branch_vald = 1'b1;
    step();
    if_a.trap_vald = 1'b0; if_a.stall_vald = 1'b0; if_a.branch_vald = 1'b0;
    check("trap_pc",    if_a.prog_cntr, 32'h100);
    check("trap_b_epc", if_b.epc, 32'h1C);
    check("trap_a_epc", if_a.epc, 32'h40);
    check("trap_redir", 32'(if_a.redirect_vald), 32'h1);

    // 5: compressed stepping (C_EXT=1 on a, 0 on b)
    if_a.jalr_vald = 1'b1; if_a.jalr_addr = 32'h0;
    step();
    if_a.jalr_vald = 1'b0; if_a.ilen16 = 1'b1;
    step(); check("c_a_2", if_a.prog_cntr, 32'h2); check("c_b_4", if_b.prog_cntr, 32'h4);
    step(); check("c_a_4", if_a.prog_cntr, 32'h4); check("c_b_8", if_b.prog_cntr, 32'h8);
    if_a.ilen16 = 1'b0;
    step(); check("c_a_8", if_a.prog_cntr, 32'h8); check("c_b_C", if_b.prog_cntr, 32'hC);

    // 6: wrap at the top of the address space, then async reset
    if_a.jalr_vald = 1'b1; if_a.jalr_addr = 32'hFFFF_FFFC;
    step();
    if_a.jalr_vald = 1'b0;
    check("wrap_pre", if_a.prog_cntr, 32'hFFFF_FFFC);
    step();
    check("wrap_a", if_a.prog_cntr, 32'h0);
    check("wrap_b", if_b.prog_cntr, 32'h0);
    step();
    #2 srst_n = 1'b0;
    #1;
    check("arst_pc",    if_a.prog_cntr, 32'h0);
    check("arst_epc",   if_a.epc, 32'h0);
    check("arst_b_epc", if_b.epc, 32'h0);
    check("arst_base",  if_a.prog_cntr_base, 32'h0);
    step();
    srst_n = 1'b1;
    step(); check("post_rst_a", if_a.prog_cntr, 32'h4);
    step(); check("post_rst_b", if_b.prog_cntr, 32'h8);
    step();

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_cntr_param.md
Name: prog_cntr_param

Overview:
Parametrised next-generation program counter for the in-order RISC-V core. It generates the fetch PC each cycle and keeps a configurable-depth PC history, so branches resolved N stages after fetch compute their target from the correct base PC. Compared with the previous PC block, it adds a trap redirect with a captured exception PC, optional 16-bit (compressed) sequential stepping, and a registered redirect indicator for downstream flush logic. It sits at the front of the fetch stage and drives the instruction-memory address.

Parameters:
XLEN, 32, width of PC, immediate and target addresses
RESET_VEC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded on trap_vald
HIST_DEPTH, 1, number of stages between fetch and branch resolution (min 1, max 8)
C_EXT, 0, 1 enables 2-byte sequential step when ilen16 is high

Ports:
clk  input  1  core clock, all state on rising edge
srst_n  input  1  reset, asynchronous assert, active-low
stall_vald  input  1  hold PC and history this cycle
trap_vald  input  1  redirect to TRAP_VEC, capture epc
jalr_vald  input  1  redirect to jalr_addr
jalr_addr  input  XLEN  jalr target; bit0 cleared before use
branch_vald  input  1  taken branch/jal resolved at stage HIST_DEPTH
imm  input  XLEN  sign-extended branch offset
ilen16  input  1  current fetched instruction is compressed (ignored if C_EXT=0)
prog_cntr  output  XLEN  current fetch PC (registered)
prog_cntr_base  output  XLEN  pc_hist[HIST_DEPTH-1], branch base PC
redirect_vald  output  1  registered; high in the cycle prog_cntr holds a non-sequential target
epc  output  XLEN  base PC captured on trap

Behaviour:
- Reset (srst_n=0, asynchronous): prog_cntr=RESET_VEC; every pc_hist entry=RESET_VEC; redirect_vald=0; epc=0. Reset deasserted mid-operation restarts fetch at RESET_VEC on the first edge after release, with no other pending state.
- Next-PC priority, evaluated every cycle, highest first:
  1. trap_vald: next=TRAP_VEC; epc<=prog_cntr_base.
  2. stall_vald: next=prog_cntr.
  3. jalr_vald: next={jalr_addr[XLEN-1:1],1'b0}.
  4. branch_vald: next=prog_cntr_base+imm.
  5. Default: next=prog_cntr+step, where step=2 if C_EXT=1 and ilen16=1, otherwise step=4.
- Latency: prog_cntr takes next on the following rising edge, so a redirect is visible one cycle after its valid.
- History register: pc_hist is HIST_DEPTH entries deep.
  - When stall_vald=0 or trap_vald=1: pc_hist[0]<=prog_cntr and pc_hist[i]<=pc_hist[i-1].
  - When stall_vald=1 and trap_vald=0: all entries hold.
  - Shifting continues across redirects; squashing wrong-path stages is the pipeline's job.
  - With HIST_DEPTH=1 and C_EXT=0, the block is cycle-equivalent to the previous-generation PC plus the trap path.
- redirect_vald<=trap_vald | (~stall_vald & (jalr_vald | branch_vald)). It is 0 for sequential and stall cycles.
- Arithmetic is modulo 2^XLEN: prog_cntr+step and base+imm wrap silently, with no carry out. imm is used at full width with no extra shift.
- Simultaneous events:
  - trap with anything: trap wins.
  - stall with jalr or branch: stall wins, and the redirect is lost; the hazard unit must re-present it.
  - jalr with branch: jalr wins.
- epc updates only on trap; otherwise it holds.
- No alignment fault is raised. Targets with bit1 set when C_EXT=0 are passed through; bit0 is forced to 0 only on the jalr path.

Test Plan:
1. Reset release, no valids, 4 cycles -> prog_cntr 0x0,0x4,0x8,0xC; redirect_vald=0; prog_cntr_base lags prog_cntr by HIST_DEPTH cycles.
2. HIST_DEPTH=3: run from 0x0 to prog_cntr=0x14, then branch_vald with imm=0x20 -> prog_cntr=0x28 (base 0x8+0x20); redirect_vald=1 that cycle only.
3. At prog_cntr=0x40, assert stall_vald and jalr_vald (addr 0x201) together for 2 cycles, then release with jalr_vald still high -> PC holds 0x40 for both stall cycles, then becomes 0x200; the history does not shift during the stall.
4. trap_vald together with stall_vald and branch_vald, base=0x1C -> prog_cntr=TRAP_VEC 0x100; epc=0x1C; redirect_vald=1.
5. C_EXT=1: from 0x0, ilen16 pattern 1,1,0 -> prog_cntr 0x2,0x4,0x8. With C_EXT=0 and the same pattern -> 0x4,0x8,0xC.
6. Wrap and reset: prog_cntr=0xFFFF_FFFC sequential -> 0x0. Assert srst_n low asynchronously between edges -> prog_cntr=RESET_VEC immediately, epc=0.
